noise_inject_mc: RTL and testbench

Multi-channel, parametrised noise injector for the SERDES channel model. It loads a DATA_W-bit signed noise table from on-chip memory through a wide read port. After loading, it adds one table sample per channel per accepted input beat, with saturation. The table index for each channel comes from an independent 32-bit LFSR, so the table contents define the noise distribution. It sits between the TX symbol source and the channel/equaliser path.

---
 rtl/noise_inj_pkg.sv | 49 ++++
 rtl/noise_lfsr32.sv | 24 ++
 rtl/noise_inject_mc.sv | 145 ++++++++++++++
 tb/tb_noise_inject_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_inj_pkg.sv
// Shared types and arithmetic helpers for the multi-channel noise injector.
// Holds the FSM state type, the LFSR step and a width-generic saturating add.
package noise_inj_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int          SAT_MAX_W = 32;

  // sat sits in the LSB so callers can take value[w-1:0] and sat with one size cast.
  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 sat;
  } sat_res_t;

  // Galois right-shift step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // a and b are sign-extended w-bit operands; the result clamps to the w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int unsigned                 w);
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t                  res;
    sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi  = ((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1);
    lo  = ~hi;
    if (sum > hi) begin
      res.value = hi[SAT_MAX_W-1:0];
      res.sat   = 1'b1;
    end else if (sum < lo) begin
      res.value = lo[SAT_MAX_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = sum[SAT_MAX_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/noise_lfsr32.sv
// One 32-bit Galois LFSR noise lane; steps once per advance pulse.
// Synchronous active-low reset loads the per-lane seed.
module noise_lfsr32
  import noise_inj_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        advance,
  output logic [31:0] state
);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/noise_inject_mc.sv
// Multi-channel noise injector: loads a signed noise table from memory, then adds
// one LFSR-indexed table sample per channel to each accepted beat, with saturation.
module noise_inject_mc
  import noise_inj_pkg::*;
#(
  parameter  int          DATA_W      = 8,
  parameter  int          TABLE_DEPTH = 128,
  parameter  int          MEM_W       = 64,
  parameter  int          CHANNELS    = 2,
  parameter  int          MEM_LATENCY = 1,
  parameter  logic [31:0] SEED        = 32'hACE1_2468,
  localparam int          LANES       = MEM_W / DATA_W,
  localparam int          WORDS       = TABLE_DEPTH / LANES,
  localparam int          AW          = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int          IW          = $clog2(TABLE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       load_start,
  output logic                       mem_rd,
  output logic [AW-1:0]              mem_addr,
  input  logic [MEM_W-1:0]           mem_rdata,
  output logic                       load_done,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic [CHANNELS-1:0]        sat
);

  state_t state, state_nx;

  logic                          accept;
  logic                          load_go;
  logic                          last_cap;
  logic [TABLE_DEPTH*DATA_W-1:0] tbl;
  logic [MEM_LATENCY-1:0]        cap_v;
  logic [AW-1:0]                 cap_a [MEM_LATENCY];
  logic [31:0]                   lfsr_state [CHANNELS];
  logic                          lfsr_hi_unused;
  logic                          v1;
  logic [CHANNELS*DATA_W-1:0]    s1_in;
  logic [CHANNELS*DATA_W-1:0]    s1_noise;

  assign load_go   = load_start && (state != LOAD);
  assign last_cap  = (state == LOAD) && cap_v[MEM_LATENCY-1]
                     && (cap_a[MEM_LATENCY-1] == AW'(WORDS - 1));
  assign accept    = (state == RUN) && en && in_valid;
  assign load_done = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned,
  // which is what keeps this combinational block from inferring a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_start) state_nx = LOAD;
      LOAD:    if (last_cap)   state_nx = RUN;
      RUN:     if (load_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else if (load_go) begin
      mem_rd   <= 1'b1;
      mem_addr <= '0;
    end else if (mem_rd) begin
      if (mem_addr == AW'(WORDS - 1)) mem_rd   <= 1'b0;
      else                            mem_addr <= mem_addr + 1'b1;
    end
  end

  // Request tags ride alongside the memory latency so each return lands at its own word.
  // NOTE: the table is flops rather than a RAM macro, so it can and must be cleared
  // by reset; a real RAM would instead need an explicit clear sequence.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cap_v <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) cap_a[i] <= '0;
      tbl   <= '0;
    end else begin
      cap_v[0] <= mem_rd;
      cap_a[0] <= mem_addr;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        cap_v[i] <= cap_v[i-1];
        cap_a[i] <= cap_a[i-1];
      end
      if ((state == LOAD) && cap_v[MEM_LATENCY-1])
        tbl[cap_a[MEM_LATENCY-1]*MEM_W +: MEM_W] <= mem_rdata;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [31:0] CH_SEED = SEED ^ (32'h9E37_79B9 * 32'(c + 1));
    noise_lfsr32 #(.SEED(CH_SEED)) u_lfsr (
      .clk     (clk),
      .rstn    (rstn),
      .advance (accept),
      .state   (lfsr_state[c])
    );
  end

  // Only the low IW bits index the table; the rest of each LFSR is deliberately ignored.
  always_comb begin
    lfsr_hi_unused = 1'b0;
    for (int c = 0; c < CHANNELS; c++) lfsr_hi_unused = lfsr_hi_unused ^ (^lfsr_state[c][31:IW]);
  end

  // A reload drops whatever is in flight so old-table samples never reach the output.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1        <= 1'b0;
      s1_in     <= '0;
      s1_noise  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= '0;
    end else begin
      v1        <= accept && !load_go;
      out_valid <= v1 && !load_go;
      if (accept) begin
        s1_in <= in_data;
        for (int c = 0; c < CHANNELS; c++)
          s1_noise[c*DATA_W +: DATA_W] <= tbl[lfsr_state[c][IW-1:0]*DATA_W +: DATA_W];
      end
      if (v1) begin
        for (int c = 0; c < CHANNELS; c++)
          {out_data[c*DATA_W +: DATA_W], sat[c]} <= (DATA_W + 1)'(sat_add(
              SAT_MAX_W'(signed'(s1_in[c*DATA_W +: DATA_W])),
              SAT_MAX_W'(signed'(s1_noise[c*DATA_W +: DATA_W])),
              DATA_W));
      end
    end
  end

endmodule

// File: tb/tb_noise_inject_mc.sv
// Directed bench for noise_inject_mc at default parameters, with a cycle-level
// reference model of table, LFSRs and pipeline checked every cycle.
module tb_noise_inject_mc;

  localparam int          DATA_W      = 8;
  localparam int          TABLE_DEPTH = 128;
  localparam int          MEM_W       = 64;
  localparam int          CHANNELS    = 2;
  localparam int          MEM_LATENCY = 1;
  localparam logic [31:0] SEED        = 32'hACE1_2468;
  localparam int          LANES       = 8;
  localparam int          WORDS       = 16;
  localparam int          AW          = 4;
  localparam int          IW          = 7;
  localparam int          LOAD_LAT    = 18;

  logic          clk = 1'b0;
  logic          rstn;
  logic          load_start;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_rdata;
  logic          load_done;
  logic          en;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [1:0]    sat;

  noise_inject_mc #(
    .DATA_W(DATA_W), .TABLE_DEPTH(TABLE_DEPTH), .MEM_W(MEM_W),
    .CHANNELS(CHANNELS), .MEM_LATENCY(MEM_LATENCY), .SEED(SEED)
  ) dut (
    .clk(clk), .rstn(rstn), .load_start(load_start), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .load_done(load_done),
    .en(en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Memory image and a responder honouring MEM_LATENCY.
  logic [7:0]    mem_img [TABLE_DEPTH];
  logic          hist_v  [MEM_LATENCY];
  logic [AW-1:0] hist_a  [MEM_LATENCY];

  function automatic logic [MEM_W-1:0] word_of(input logic [AW-1:0] a);
    logic [MEM_W-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*8 +: 8] = mem_img[int'(a)*LANES + l];
    return w;
  endfunction

  always @(negedge clk) begin
    hist_v[0] <= mem_rd;
    hist_a[0] <= mem_addr;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      hist_v[i] <= hist_v[i-1];
      hist_a[i] <= hist_a[i-1];
    end
    mem_rdata <= hist_v[MEM_LATENCY-1] ? word_of(hist_a[MEM_LATENCY-1]) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  // Reference model.
  typedef enum {M_IDLE, M_LOAD, M_RUN} mst_t;
  mst_t        mst;
  int          mcnt;
  logic [7:0]  mtab  [TABLE_DEPTH];
  logic [31:0] mlfsr [CHANNELS];
  logic [7:0]  mn1   [CHANNELS];
  logic [15:0] min1;
  logic        mv1, mv2;
  logic [15:0] mout;
  logic [1:0]  msat;
  logic        mdl_on = 1'b0;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] seed_of(input int c);
    return SEED ^ 32'(32'h9E37_79B9 * (c + 1));
  endfunction

  function automatic logic [8:0] ref_sat(input logic signed [7:0] a, input logic signed [7:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s > 127)  return {1'b1, 8'h7F};
    if (s < -128) return {1'b1, 8'h80};
    return {1'b0, s[7:0]};
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      mst  <= M_IDLE;
      mcnt <= 0;
      mv1  <= 1'b0;
      mv2  <= 1'b0;
      mout <= '0;
      msat <= '0;
      for (int c = 0; c < CHANNELS; c++) mlfsr[c] <= seed_of(c);
      for (int k = 0; k < TABLE_DEPTH; k++) mtab[k] <= '0;
    end else begin
      mv2 <= mv1;
      mv1 <= (mst == M_RUN) && en && in_valid;
      if ((mst == M_RUN) && en && in_valid) begin
        min1 <= in_data;
        for (int c = 0; c < CHANNELS; c++) begin
          mlfsr[c] <= ref_step(mlfsr[c]);
          mn1[c]   <= mtab[mlfsr[c][IW-1:0]];
        end
      end
      if (mv1)
        for (int c = 0; c < CHANNELS; c++) {msat[c], mout[c*8 +: 8]} <= ref_sat(min1[c*8 +: 8], mn1[c]);
      if ((mst != M_LOAD) && load_start) begin
        mst  <= M_LOAD;
        mcnt <= 0;
        mv1  <= 1'b0;
        mv2  <= 1'b0;
      end else if (mst == M_LOAD) begin
        if (mcnt == WORDS + MEM_LATENCY - 1) begin
          mst  <= M_RUN;
          mtab <= mem_img;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("model_out_valid", out_valid, mv2);
      if (mv2) begin
        check("model_out_data", out_data, mout);
        check("model_sat", sat, msat);
      end
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < TABLE_DEPTH; k++) mem_img[k] = v;
  endtask

  task automatic do_load(input string tag);
    int lat;
    int nrd;
    lat = 1;
    nrd = 0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    while (!load_done && lat < 100) begin
      if (mem_rd) nrd++;
      tick;
      lat++;
    end
    check({tag, "_load_latency"}, lat, LOAD_LAT);
    check({tag, "_rd_cycles"}, nrd, WORDS);
  endtask

  task automatic beat(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] e0,
                      input logic [7:0] e1, input logic [1:0] es, input string tag);
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = {a1, a0};
    tick;
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    tick;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, {e1, e0});
    check({tag, "_sat"}, sat, es);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndiff;
    int bad;
    logic [7:0] v;
    rstn = 1'b0; load_start = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    fill(8'h00);
    repeat (2) tick;
    mdl_on = 1'b1;
    check("rst_load_done", load_done, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_sat", sat, '0);

    rstn = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 16'h0505;
    repeat (6) begin
      tick;
      check("idle_no_out", out_valid, 1'b0);
    end
    in_valid = 1'b0;

    fill(8'd3);
    do_load("const3");
    beat(8'd0, 8'd0, 8'd3, 8'd3, 2'b00, "const3");

    fill(8'd100);
    do_load("satpos");
    beat(8'd100, 8'd100, 8'h7F, 8'h7F, 2'b11, "sat_pos");

    fill(-8'sd100);
    do_load("satneg");
    beat(-8'sd100, -8'sd100, 8'h80, 8'h80, 2'b11, "sat_neg");

    fill(8'd5);
    do_load("five");
    beat(8'd10, 8'd10, 8'd15, 8'd15, 2'b00, "no_sat");
    beat(8'd10, 8'd124, 8'd15, 8'h7F, 2'b10, "sat_ch1_only");
    beat(8'd122, -8'sd128, 8'h7F, 8'h85, 2'b00, "edge_no_sat");

    // Ramp table, entry k = k-64; stream with a 10-cycle stall in the middle.
    for (int k = 0; k < TABLE_DEPTH; k++) mem_img[k] = 8'(k - 64);
    do_load("ramp");
    ndiff = 0;
    en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        en = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick;
          if (s >= 2) check("stall_drained", out_valid, 1'b0);
        end
        en = 1'b1;
      end
      in_valid = 1'b1;
      v        = 8'($urandom_range(0, 200) - 100);
      in_data  = {v, v};
      tick;
      if (out_valid && (out_data[7:0] != out_data[15:8])) ndiff++;
    end
    check("ch_seq_differ", ndiff > 300, 1'b1);

    // Mid-stream reload to a constant-7 table while beats keep arriving.
    in_data = '0;
    repeat (3) tick;
    fill(8'd7);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("reload_ov_drop", out_valid, 1'b0);
    check("reload_done_low", load_done, 1'b0);
    bad = 0;
    begin
      int lat;
      lat = 1;
      while (!load_done && lat < 100) begin
        if (out_valid) bad++;
        tick;
        lat++;
      end
      check("reload_latency", lat, LOAD_LAT);
    end
    check("reload_quiet", bad, 0);
    tick;
    check("reload_first_lat1", out_valid, 1'b0);
    tick;
    check("reload_first_valid", out_valid, 1'b1);
    check("reload_first_data", out_data, 16'h0707);
    in_valid = 1'b0;
    repeat (3) tick;

    // Reset in the middle of a load, then confirm a clean reload still works.
    fill(8'd2);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    repeat (5) tick;
    rstn = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
    bad = 0;
    en = 1'b1;
    in_valid = 1'b1;
    repeat (30) begin
      if (load_done || mem_rd || out_valid) bad++;
      tick;
    end
    in_valid = 1'b0;
    check("rst_midload_idle", bad, 0);
    do_load("after_rst");
    beat(8'd1, -8'sd3, 8'd3, 8'hFF, 2'b00, "after_rst");

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
